// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx                                                         |
// | Purpose  : UART frame serialiser draining a ready/valid byte source (FIFO) |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_tx #(
    parameter int unsigned P_CLK_FREQ  = 100_000_000,
    parameter int unsigned P_BAUD      = 115_200,
    parameter int unsigned P_DATA_BITS = 8,
    parameter int unsigned P_PARITY    = 0,
    parameter int unsigned P_STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [P_DATA_BITS-1:0] in_data,
    input  logic                   in_vld,
    output logic                   in_rdy,
    output logic                   tx,
    output logic                   tx_busy
);

    localparam int unsigned        c_N          = P_CLK_FREQ / P_BAUD;
    localparam int unsigned        c_CNT_W      = (c_N >= 2) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST   = c_CNT_W'(c_N - 1);
    localparam int unsigned        c_BIT_W      = 3;
    localparam logic [c_BIT_W-1:0] c_DATA_LAST  = c_BIT_W'(P_DATA_BITS - 1);
    localparam logic [c_BIT_W-1:0] c_STOP_LAST  = c_BIT_W'(P_STOP_BITS - 1);

    generate
        if (c_N < 2) begin : g_bad_baud
            $error("uart_tx: P_CLK_FREQ / P_BAUD must be at least 2");
        end
        if (P_DATA_BITS < 5 || P_DATA_BITS > 8) begin : g_bad_data_bits
            $error("uart_tx: P_DATA_BITS must be within 5..8");
        end
        if (P_PARITY > 2) begin : g_bad_parity
            $error("uart_tx: P_PARITY must be 0, 1 or 2");
        end
        if (P_STOP_BITS < 1 || P_STOP_BITS > 2) begin : g_bad_stop_bits
            $error("uart_tx: P_STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_BIT_W-1:0]     r_bit;
    logic [c_BIT_W-1:0]     w_bit_nxt;
    logic [P_DATA_BITS-1:0] r_shift;
    logic [P_DATA_BITS-1:0] w_shift_nxt;
    logic                   r_par;
    logic                   w_par_nxt;
    logic                   r_tx;
    logic                   w_tx_nxt;
    logic                   r_busy;

    logic                   w_baud_end;
    logic                   w_last_stop;
    logic                   w_xfer;
    logic                   w_par_load;

    assign w_baud_end  = (r_cnt == c_CNT_LAST);
    assign w_last_stop = (r_state == S_STOP) && w_baud_end && (r_bit == c_STOP_LAST);

    // Ready depends only on state/counter (never on in_vld) to avoid a loop through the FIFO.
    assign in_rdy     = rst_n && ((r_state == S_IDLE) || w_last_stop);
    assign w_xfer     = in_vld && in_rdy;
    assign w_par_load = (P_PARITY == 1) ? ~^in_data : ^in_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;

        if (r_state != S_IDLE) begin
            w_cnt_nxt = w_baud_end ? '0 : r_cnt + c_CNT_W'(1);
        end

        case (r_state)
            S_IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = S_START;
                    w_cnt_nxt   = '0;
                    w_shift_nxt = in_data;
                    w_par_nxt   = w_par_load;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == c_DATA_LAST) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = (P_PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + c_BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (w_baud_end) begin
                    w_state_nxt = S_STOP;
                    w_bit_nxt   = '0;
                end
            end
            S_STOP: begin
                if (w_baud_end) begin
                    if (r_bit == c_STOP_LAST) begin
                        w_bit_nxt = '0;
                        // Accepting here chains the next start bit with no idle gap.
                        if (w_xfer) begin
                            w_state_nxt = S_START;
                            w_shift_nxt = in_data;
                            w_par_nxt   = w_par_load;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end else begin
                        w_bit_nxt = r_bit + c_BIT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_tx_nxt = 1'b1;
        case (r_state)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = r_shift[0];
            S_PARITY: w_tx_nxt = r_par;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
            r_busy  <= (r_state != S_IDLE);
        end
    end

    assign tx      = r_tx;
    assign tx_busy = r_busy;

endmodule
`default_nettype wire
